awgn_out_buffer: RTL

//  Output stage placed directly after the AWGN generator. Takes the two 16-bit noise

---
 rtl/awgn_out_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/awgn_out_buffer.sv
// rtl/awgn_out_buffer.sv - warm-up gated, pair-atomic FIFO serializer for AWGN generator output
module awgn_out_buffer #(
  parameter int W      = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int WARMUP = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [W-1:0]  awgn_in_0,
  input  logic [W-1:0]  awgn_in_1,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   fill,
  output logic [15:0]   ovf_cnt,
  output logic          warm
);

  localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP);
  localparam logic [AW:0]   ROOM_LIM  = (AW + 1)'(DEPTH - 2);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] warm_cnt;
  logic [CW-1:0] warm_cnt_next;
  logic [AW:0]   fill_next;
  logic          push;
  logic          accept;
  logic          reject;
  logic          pop;

  // Space is judged on the registered fill only, so a same-cycle pop never makes room.
  assign push    = warm & en;
  assign accept  = push & (fill <= ROOM_LIM);
  assign reject  = push & ~accept;
  assign m_valid = (fill != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_comb begin
    warm_cnt_next = warm_cnt;
    if (warm_cnt != WARM_LAST) begin
      warm_cnt_next = warm_cnt + CW'(1);
    end
  end

  always_comb begin
    fill_next = fill;
    if (accept) begin
      fill_next = fill_next + (AW + 1)'(2);
    end
    if (pop) begin
      fill_next = fill_next - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      ovf_cnt  <= '0;
      warm_cnt <= '0;
      warm     <= 1'b0;
    end else begin
      warm_cnt <= warm_cnt_next;
      warm     <= warm | (warm_cnt_next == WARM_LAST);
      fill     <= fill_next;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(2);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (reject && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  // Sample storage has no reset; pointers and fill alone define what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr]          <= awgn_in_0;
      mem[wr_ptr + AW'(1)] <= awgn_in_1;
    end
  end

endmodule
